// File: rtl/racing_game_core.sv
// Game-state core for the racing game: player/enemy motion, scrolling track,
// lives/score bookkeeping and the IDLE/PLAY/CRASH/OVER FSM, all advanced once per frame.
module racing_game_core #(
    parameter int NUM_ENEMIES  = 2,
    parameter int H_ACTIVE     = 640,
    parameter int V_ACTIVE     = 480,
    parameter int PLAYER_Y     = 454,
    parameter int X_MIN        = 52,
    parameter int X_MAX        = 580,
    parameter int STEP         = 4,
    parameter int TRACK_EDGE   = 20,
    parameter int SPEED_MAX    = 250,
    parameter int LIVES        = 3,
    parameter int CRASH_FRAMES = 60
) (
    input  logic                      i_clk,
    input  logic                      i_reset,
    input  logic                      i_left,
    input  logic                      i_right,
    input  logic                      i_start,
    input  logic                      i_vsync,
    input  logic [15:0]               i_hpos,
    input  logic [15:0]               i_vpos,
    input  logic                      i_player_gfx,
    input  logic [NUM_ENEMIES-1:0]    i_enemy_gfx,
    output logic [15:0]               o_player_x,
    output logic [16*NUM_ENEMIES-1:0] o_enemy_x,
    output logic [16*NUM_ENEMIES-1:0] o_enemy_y,
    output logic [15:0]               o_track_pos,
    output logic [7:0]                o_speed,
    output logic [15:0]               o_score,
    output logic [3:0]                o_lives,
    output logic [1:0]                o_game_state,
    output logic                      o_track_gfx,
    output logic                      o_track_shoulder
);
    localparam int N = NUM_ENEMIES;
    localparam logic [15:0] L_XMIN    = 16'(X_MIN);
    localparam logic [15:0] L_XMAX    = 16'(X_MAX);
    localparam logic [15:0] L_STEP    = 16'(STEP);
    localparam logic [15:0] L_VACT    = 16'(V_ACTIVE);
    localparam logic [15:0] L_EDGE    = 16'(TRACK_EDGE);
    localparam logic [15:0] L_EDGE_HI = 16'(H_ACTIVE - TRACK_EDGE);
    localparam logic [15:0] L_SH      = 16'(2 * TRACK_EDGE);
    localparam logic [15:0] L_SH_HI   = 16'(H_ACTIVE - 2 * TRACK_EDGE);
    localparam logic [15:0] L_PX0     = 16'(H_ACTIVE / 2);
    localparam logic [15:0] L_CRASH   = 16'(CRASH_FRAMES - 1);
    localparam logic [7:0]  L_SMAX    = 8'(SPEED_MAX);
    localparam logic [3:0]  L_LIVES   = 4'(LIVES);

    typedef enum logic [1:0] {S_IDLE = 2'd0, S_PLAY = 2'd1, S_CRASH = 2'd2, S_OVER = 2'd3} state_t;

    function automatic logic [15:0] f_init_x(input int i);
        return 16'(X_MIN + (i + 1) * (X_MAX - X_MIN) / (N + 1));
    endfunction
    function automatic logic [15:0] f_init_y(input int i);
        return 16'(i * (V_ACTIVE / N));
    endfunction

    state_t        r_state, w_next;
    logic          r_vs, r_tick, r_coll;
    logic [15:0]   r_timer, r_px, r_track, r_score;
    logic [7:0]    r_speed;
    logic [3:0]    r_lives;
    logic [15:0]   r_ex [N];
    logic [15:0]   r_ey [N];
    logic [N-1:0]  r_edir;

    logic          w_offside, w_hit_px, w_reload, w_move, w_hit, w_tdec;
    logic [15:0]   w_px_nxt, w_score_nxt;
    logic [16:0]   w_score_sum, w_ysum;
    logic [7:0]    w_speed_nxt;
    logic [3:0]    w_wraps;
    logic [15:0]   w_ex_nxt [N];
    logic [15:0]   w_ey_nxt [N];
    logic [N-1:0]  w_edir_nxt;
    logic          w_unused;

    assign w_offside        = (i_hpos < L_EDGE) || (i_hpos >= L_EDGE_HI);
    assign w_hit_px         = i_player_gfx && ((|i_enemy_gfx) || w_offside);
    assign o_track_gfx      = w_offside && (i_vpos[5:1] != r_track[5:1]);
    assign o_track_shoulder = (i_hpos < L_SH) || (i_hpos >= L_SH_HI);
    assign w_unused         = &{1'b0, i_vpos[15:6], i_vpos[0], 16'(PLAYER_Y)};

    // Frame tick is a registered falling edge of vsync.
    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            r_vs   <= 1'b1;
            r_tick <= 1'b0;
            r_coll <= 1'b0;
        end else begin
            r_vs   <= i_vsync;
            r_tick <= r_vs && !i_vsync;
            if (w_hit_px)    r_coll <= 1'b1;
            else if (r_tick) r_coll <= 1'b0;
        end
    end

    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) r_state <= S_IDLE;
        else          r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE, S_OVER: if (r_tick && i_start) w_next = S_PLAY;
            S_PLAY:         if (r_tick && r_coll) w_next = (r_lives == 4'd1) ? S_OVER : S_CRASH;
            S_CRASH:        if (r_tick && r_timer == '0) w_next = S_PLAY;
            default:        w_next = S_IDLE;
        endcase
    end

    always_comb begin
        w_reload = 1'b0;
        w_move   = 1'b0;
        w_hit    = 1'b0;
        w_tdec   = 1'b0;
        case (r_state)
            S_IDLE, S_OVER: w_reload = r_tick && i_start;
            S_PLAY: begin
                w_move = r_tick && !r_coll;
                w_hit  = r_tick && r_coll;
            end
            S_CRASH:        w_tdec = r_tick && (r_timer != '0);
            default: ;
        endcase
    end

    always_comb begin
        w_px_nxt = r_px;
        if (i_left && !i_right)
            w_px_nxt = (r_px < L_XMIN + L_STEP) ? L_XMIN : r_px - L_STEP;
        else if (i_right && !i_left)
            w_px_nxt = ({1'b0, r_px} + {1'b0, L_STEP} > {1'b0, L_XMAX}) ? L_XMAX : r_px + L_STEP;
        w_speed_nxt = r_speed;
        if (r_speed < L_SMAX)      w_speed_nxt = r_speed + 8'd1;
        else if (r_speed > L_SMAX) w_speed_nxt = r_speed - 8'd1;
    end

    // Enemies bounce off the limits; y wraps count towards the score.
    always_comb begin
        w_wraps = '0;
        w_ysum  = '0;
        for (int i = 0; i < N; i++) begin
            w_ysum = {1'b0, r_ey[i]} + {13'b0, r_speed[7:4]};
            if (w_ysum >= {1'b0, L_VACT}) begin
                w_ey_nxt[i] = '0;
                w_wraps     = w_wraps + 4'd1;
            end else begin
                w_ey_nxt[i] = w_ysum[15:0];
            end
            if (r_ex[i] == L_XMIN) begin
                w_edir_nxt[i] = 1'b1;
                w_ex_nxt[i]   = r_ex[i] + L_STEP;
            end else if (r_ex[i] == L_XMAX) begin
                w_edir_nxt[i] = 1'b0;
                w_ex_nxt[i]   = r_ex[i] - L_STEP;
            end else begin
                w_edir_nxt[i] = r_edir[i];
                w_ex_nxt[i]   = r_edir[i] ? r_ex[i] + L_STEP : r_ex[i] - L_STEP;
            end
        end
        w_score_sum = {1'b0, r_score} + {13'b0, w_wraps};
        w_score_nxt = w_score_sum[16] ? 16'hFFFF : w_score_sum[15:0];
    end

    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            r_px <= L_PX0; r_speed <= '0; r_track <= '0; r_score <= '0;
            r_lives <= '0; r_timer <= '0;
            for (int i = 0; i < N; i++) begin
                r_ex[i] <= f_init_x(i); r_ey[i] <= f_init_y(i); r_edir[i] <= i[0];
            end
        end else if (w_reload) begin
            r_px <= L_PX0; r_speed <= 8'd31; r_track <= '0; r_score <= '0;
            r_lives <= L_LIVES; r_timer <= '0;
            for (int i = 0; i < N; i++) begin
                r_ex[i] <= f_init_x(i); r_ey[i] <= f_init_y(i); r_edir[i] <= i[0];
            end
        end else if (w_move) begin
            r_px    <= w_px_nxt;
            r_speed <= w_speed_nxt;
            r_track <= r_track + {12'b0, r_speed[7:4]};
            r_score <= w_score_nxt;
            r_edir  <= w_edir_nxt;
            for (int i = 0; i < N; i++) begin
                r_ex[i] <= w_ex_nxt[i]; r_ey[i] <= w_ey_nxt[i];
            end
        end else if (w_hit) begin
            r_speed <= 8'd16;
            r_lives <= r_lives - 4'd1;
            r_timer <= (r_lives == 4'd1) ? 16'd0 : L_CRASH;
        end else if (w_tdec) begin
            r_timer <= r_timer - 16'd1;
        end
    end

    assign o_player_x   = r_px;
    assign o_track_pos  = r_track;
    assign o_speed      = r_speed;
    assign o_score      = r_score;
    assign o_lives      = r_lives;
    assign o_game_state = r_state;

    for (genvar g = 0; g < N; g++) begin : g_pack
        assign o_enemy_x[16*g +: 16] = r_ex[g];
        assign o_enemy_y[16*g +: 16] = r_ey[g];
    end
endmodule

// File: tb/tb_racing_game_core.sv
// Bench for racing_game_core: combinational track vectors, directed game sequences
// and randomized frames checked against a frame-level game model.
module tb_racing_game_core;
    localparam int N = 2;

    logic          clk = 1'b0, rst_n = 1'b0;
    logic          left = 0, right = 0, start = 0, vsync = 1, pgfx = 0;
    logic [15:0]   hpos = 16'd320, vpos = 16'd0;
    logic [N-1:0]  egfx = '0;
    logic [15:0]   px, track, score;
    logic [16*N-1:0] ex, ey;
    logic [7:0]    speed;
    logic [3:0]    lives;
    logic [1:0]    gstate;
    logic          tgfx, tsh;

    racing_game_core #(.NUM_ENEMIES(N)) dut (
        .i_clk(clk), .i_reset(rst_n), .i_left(left), .i_right(right), .i_start(start),
        .i_vsync(vsync), .i_hpos(hpos), .i_vpos(vpos), .i_player_gfx(pgfx), .i_enemy_gfx(egfx),
        .o_player_x(px), .o_enemy_x(ex), .o_enemy_y(ey), .o_track_pos(track), .o_speed(speed),
        .o_score(score), .o_lives(lives), .o_game_state(gstate), .o_track_gfx(tgfx),
        .o_track_shoulder(tsh));

    always #5 clk = ~clk;

    int checks = 0, errors = 0;

    // Frame-level model of the game rules.
    int m_state, m_px, m_speed, m_track, m_score, m_lives, m_timer;
    int m_ex[N], m_ey[N], m_dir[N];
    bit m_coll;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d", nm, act, exp);
        end
    endtask

    function automatic void m_load_positions();
        m_px = 320; m_track = 0; m_timer = 0;
        for (int i = 0; i < N; i++) begin
            m_ex[i] = 52 + (i + 1) * 528 / (N + 1);
            m_ey[i] = i * (480 / N);
            m_dir[i] = i % 2;
        end
    endfunction

    function automatic void m_reset();
        m_state = 0; m_speed = 0; m_score = 0; m_lives = 0; m_coll = 0;
        m_load_positions();
    endfunction

    function automatic void m_frame();
        int step;
        case (m_state)
            0, 3: if (start) begin
                m_load_positions();
                m_state = 1; m_lives = 3; m_score = 0; m_speed = 31;
            end
            1: if (m_coll) begin
                m_lives--; m_speed = 16;
                if (m_lives == 0) m_state = 3;
                else begin m_state = 2; m_timer = 59; end
            end else begin
                if (left && !right) m_px -= 4;
                if (right && !left) m_px += 4;
                if (m_px < 52) m_px = 52;
                if (m_px > 580) m_px = 580;
                step = m_speed / 16;
                if (m_speed < 250) m_speed++;
                else if (m_speed > 250) m_speed--;
                m_track = (m_track + step) % 65536;
                for (int i = 0; i < N; i++) begin
                    m_ey[i] += step;
                    if (m_ey[i] >= 480) begin
                        m_ey[i] = 0;
                        if (m_score < 65535) m_score++;
                    end
                    if (m_ex[i] == 52)       begin m_dir[i] = 1; m_ex[i] += 4; end
                    else if (m_ex[i] == 580) begin m_dir[i] = 0; m_ex[i] -= 4; end
                    else m_ex[i] += m_dir[i] ? 4 : -4;
                end
            end
            2: if (m_timer == 0) m_state = 1; else m_timer--;
            default: ;
        endcase
        m_coll = 0;
    endfunction

    task automatic check_all(input string tag);
        chk({tag, ".state"}, 32'(gstate), 32'(m_state));
        chk({tag, ".player_x"}, 32'(px), 32'(m_px));
        chk({tag, ".speed"}, 32'(speed), 32'(m_speed));
        chk({tag, ".track_pos"}, 32'(track), 32'(m_track));
        chk({tag, ".score"}, 32'(score), 32'(m_score));
        chk({tag, ".lives"}, 32'(lives), 32'(m_lives));
        for (int i = 0; i < N; i++) begin
            chk($sformatf("%s.enemy_x%0d", tag, i), 32'(ex[16*i +: 16]), 32'(m_ex[i]));
            chk($sformatf("%s.enemy_y%0d", tag, i), 32'(ey[16*i +: 16]), 32'(m_ey[i]));
        end
    endtask

    // One frame: vsync low for a few cycles, then back high; ends on a negedge.
    task automatic do_tick();
        @(negedge clk) vsync = 1'b0;
        repeat (3) @(negedge clk);
        vsync = 1'b1;
        repeat (2) @(negedge clk);
        m_frame();
    endtask

    // Single-cycle sprite pixel mid-frame; kind 0 enemy overlap, 1 offside, 2 clear road.
    task automatic pulse(input int kind);
        @(negedge clk);
        pgfx = 1'b1;
        egfx = (kind == 0) ? N'(1) : '0;
        hpos = (kind == 1) ? 16'd5 : 16'd300;
        @(negedge clk);
        pgfx = 1'b0; egfx = '0; hpos = 16'd320;
        if (kind != 2) m_coll = 1;
    endtask

    typedef struct {
        logic [15:0] h;
        logic [15:0] v;
        logic        gfx;
        logic        sh;
    } vec_t;
    vec_t vt[11];

    initial begin
        int saved_px, h, v, k;
        bit off;
        vt[0]  = '{16'd0,   16'd0,  1'b0, 1'b1};
        vt[1]  = '{16'd0,   16'd2,  1'b1, 1'b1};
        vt[2]  = '{16'd19,  16'd4,  1'b1, 1'b1};
        vt[3]  = '{16'd20,  16'd4,  1'b0, 1'b1};
        vt[4]  = '{16'd39,  16'd4,  1'b0, 1'b1};
        vt[5]  = '{16'd40,  16'd4,  1'b0, 1'b0};
        vt[6]  = '{16'd600, 16'd2,  1'b0, 1'b1};
        vt[7]  = '{16'd619, 16'd2,  1'b0, 1'b1};
        vt[8]  = '{16'd620, 16'd2,  1'b1, 1'b1};
        vt[9]  = '{16'd639, 16'd64, 1'b0, 1'b1};
        vt[10] = '{16'd320, 16'd2,  1'b0, 1'b0};

        m_reset();
        repeat (3) @(negedge clk);
        check_all("reset");
        chk("reset.px_const", 32'(px), 32'd320);
        chk("reset.ex1_const", 32'(ex[31:16]), 32'd404);
        rst_n = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 11; i++) begin
            hpos = vt[i].h; vpos = vt[i].v;
            #1;
            chk($sformatf("vec%0d.track_gfx", i), 32'(tgfx), 32'(vt[i].gfx));
            chk($sformatf("vec%0d.shoulder", i), 32'(tsh), 32'(vt[i].sh));
        end
        hpos = 16'd320;

        do_tick();
        check_all("idle_nostart");
        start = 1; do_tick(); start = 0;
        check_all("start");
        chk("start.speed_const", 32'(speed), 32'd31);

        left = 1;
        for (int i = 0; i < 100; i++) begin
            do_tick();
            check_all("left");
        end
        chk("left.clamp", 32'(px), 32'd52);
        right = 1; do_tick(); check_all("both");
        left = 0; right = 0;

        for (int i = 0; i < 220; i++) begin
            start = (i == 50);
            do_tick();
            check_all("cruise");
        end
        start = 0;
        chk("cruise.speed_max", 32'(speed), 32'd250);

        pulse(2); do_tick(); check_all("nearmiss");
        for (int c = 0; c < 3; c++) begin
            pulse(c == 1 ? 1 : 0);
            do_tick();
            check_all($sformatf("crash%0d", c));
            if (c < 2) begin
                saved_px = m_px;
                left = 1; start = 1;
                for (int t = 0; t < 60; t++) begin
                    if (t == 20) pulse(0);
                    do_tick();
                end
                left = 0; start = 0;
                check_all($sformatf("crash%0d.recover", c));
                chk("crash.frozen_px", 32'(px), 32'(saved_px));
            end
        end
        chk("over.lives_const", 32'(lives), 32'd0);
        start = 1;
        repeat (10) @(negedge clk);
        check_all("over.start_no_tick");
        do_tick(); start = 0;
        check_all("restart");

        for (int i = 0; i < 300; i++) begin
            h = $urandom_range(0, 639); v = $urandom_range(0, 479);
            hpos = 16'(h); vpos = 16'(v);
            #1;
            off = (h < 20) || (h >= 620);
            chk("rand.track_gfx", 32'(tgfx), 32'(off && (((v >> 1) % 32) != ((m_track >> 1) % 32))));
            hpos = 16'd320;
            left = $urandom_range(0, 1); right = $urandom_range(0, 1);
            start = ($urandom_range(0, 7) == 0);
            k = $urandom_range(0, 19);
            if (k < 3) pulse(k);
            do_tick();
            check_all("rand");
        end
        left = 0; right = 0; start = 0;

        rst_n = 1'b0; @(negedge clk); rst_n = 1'b1; m_reset();
        start = 1; do_tick(); start = 0;
        pulse(0); do_tick(); do_tick(); do_tick();
        check_all("precrash");
        @(negedge clk);
        vsync = 1'b0;
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        m_reset();
        check_all("async_reset");
        vsync = 1'b1;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
